// File: rtl/servo_pwm_slew_pkg.sv
// ---------------------------------------------------------------------------
// servo_pkg
// Shared constants, the pulse-width type and the pulse arithmetic helpers
// used by the servo PWM output stage.
//   CLK_HZ / US_DIV  : system clock and derived cycles-per-microsecond
//   FRAME_US         : default frame length, us
//   PUL_MIN/PUL_MAX  : default safe pulse range, us
//   PUL_CENTER       : default post-reset pulse width (servo centre), us
//   SLEW_US          : default per-frame slew limit, us
//   clamp_us()       : clamp a command into [lo, hi]
//   slew_step()      : move a width toward a target by at most lim us
// ---------------------------------------------------------------------------
package servo_pkg;

  localparam int CLK_HZ     = 50_000_000;
  localparam int US_DIV     = CLK_HZ / 1_000_000;
  localparam int FRAME_US   = 20000;
  localparam int PUL_MIN    = 500;
  localparam int PUL_MAX    = 2500;
  localparam int PUL_CENTER = 1500;
  localparam int SLEW_US    = 20;

  typedef logic [15:0] pulse_us_t;

  function automatic pulse_us_t clamp_us(input pulse_us_t v,
                                         input pulse_us_t lo,
                                         input pulse_us_t hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

  // The difference is taken in 17-bit signed so a large downward step can
  // never wrap into a large upward one. lim == 0 means snap to target.
  function automatic pulse_us_t slew_step(input pulse_us_t cur,
                                          input pulse_us_t tgt,
                                          input pulse_us_t lim);
    logic signed [16:0] diff;
    logic signed [16:0] s_lim;
    diff  = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    s_lim = $signed({1'b0, lim});
    if (lim == '0 || (diff <= s_lim && diff >= -s_lim)) return tgt;
    else if (diff > 0)                                  return cur + lim;
    else                                                return cur - lim;
  endfunction

endpackage

// File: rtl/servo_pwm_slew_if.sv
// ---------------------------------------------------------------------------
// servo_pwm_slew_if
// Command/status bundle between the gait generator and one servo channel.
//   en          : run request (gait -> servo)
//   pul_len     : commanded pulse width, us (gait -> servo)
//   CTL         : servo PWM line (servo -> pin)
//   frame_start : one-cycle pulse on the first cycle of each frame
//   pul_applied : width in force for the current frame, us
//   sat         : command was clamped at the last frame boundary
// master = command source, slave = PWM channel.
// ---------------------------------------------------------------------------
interface servo_pwm_slew_if;
  import servo_pkg::*;

  logic      en;
  pulse_us_t pul_len;
  logic      CTL;
  logic      frame_start;
  pulse_us_t pul_applied;
  logic      sat;

  modport master (output en, output pul_len,
                  input  CTL, input frame_start, input pul_applied, input sat);
  modport slave  (input  en, input pul_len,
                  output CTL, output frame_start, output pul_applied, output sat);
endinterface

// File: rtl/servo_pwm_slew_us_tick_gen.sv
// ---------------------------------------------------------------------------
// us_tick_gen
// Microsecond prescaler: counts 0..CLK_DIV-1 while i_run is high and emits
// o_tick on the last count. Held at 0 while idle or on i_clr.
//   clk, rst : clock, synchronous active-high reset
//   i_run    : count enable
//   i_clr    : restart the prescaler from 0
//   o_tick   : one-cycle microsecond strobe
// ---------------------------------------------------------------------------
module us_tick_gen #(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  input  logic i_clr,
  output logic o_tick
);

  localparam int            W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0]  LAST = W'(CLK_DIV - 1);

  logic [W-1:0] r_div_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr || !i_run) r_div_cnt <= '0;
    else if (r_div_cnt == LAST) r_div_cnt <= '0;
    else                        r_div_cnt <= r_div_cnt + 1'b1;
  end

  assign o_tick = i_run && (r_div_cnt == LAST);

endmodule

// File: rtl/servo_pwm_slew.sv
// ---------------------------------------------------------------------------
// servo_pwm_slew
// Per-joint hobby-servo PWM output stage. Latches the commanded width only
// at frame boundaries, clamps it to [PUL_MIN, PUL_MAX] and limits its change
// to SLEW_US per frame, so pulses are never truncated or jerked.
//   CLK, rst : clock, synchronous active-high reset
//   bus      : servo_pwm_slew_if.slave (en, pul_len in;
//              CTL, frame_start, pul_applied, sat out)
// ---------------------------------------------------------------------------
module servo_pwm_slew #(
  parameter int CLK_DIV   = servo_pkg::US_DIV,
  parameter int FRAME_US  = servo_pkg::FRAME_US,
  parameter int PUL_MIN   = servo_pkg::PUL_MIN,
  parameter int PUL_MAX   = servo_pkg::PUL_MAX,
  parameter int PUL_RESET = servo_pkg::PUL_CENTER,
  parameter int SLEW_US   = servo_pkg::SLEW_US
) (
  input  logic             CLK,
  input  logic             rst,
  servo_pwm_slew_if.slave  bus
);
  import servo_pkg::*;

  if (!(PUL_MIN <= PUL_RESET && PUL_RESET <= PUL_MAX && PUL_MAX < FRAME_US))
  begin : g_bad_range
    $error("servo_pwm_slew: need PUL_MIN <= PUL_RESET <= PUL_MAX < FRAME_US");
  end
  if (CLK_DIV < 1 || FRAME_US >= 65536) begin : g_bad_timing
    $error("servo_pwm_slew: need CLK_DIV >= 1 and FRAME_US < 65536");
  end

  localparam pulse_us_t LAST_US = pulse_us_t'(FRAME_US - 1);
  localparam pulse_us_t P_MIN   = pulse_us_t'(PUL_MIN);
  localparam pulse_us_t P_MAX   = pulse_us_t'(PUL_MAX);
  localparam pulse_us_t P_RST   = pulse_us_t'(PUL_RESET);
  localparam pulse_us_t P_SLEW  = pulse_us_t'(SLEW_US);

  logic      r_run;
  logic      r_ctl;
  logic      r_frame_start;
  logic      r_sat;
  pulse_us_t r_us_cnt;
  pulse_us_t r_pul_applied;

  logic      w_tick;
  logic      w_start;
  logic      w_frame;
  logic      w_load;
  logic      w_run_next;
  logic      w_sat_next;
  pulse_us_t w_target;
  pulse_us_t w_us_cnt_next;
  pulse_us_t w_applied_next;

  us_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (CLK),
    .rst    (rst),
    .i_run  (r_run),
    .i_clr  (w_start),
    .o_tick (w_tick)
  );

  // Next-state values are computed first so CTL can be registered from them;
  // this makes CTL rise on the same cycle frame_start is high.
  always_comb begin
    w_start        = !r_run && bus.en;
    w_frame        = r_run && w_tick && (r_us_cnt == LAST_US);
    w_load         = w_start || (w_frame && bus.en);
    w_target       = clamp_us(bus.pul_len, P_MIN, P_MAX);
    w_sat_next     = r_sat;
    w_applied_next = r_pul_applied;
    w_run_next     = r_run;
    w_us_cnt_next  = r_us_cnt;

    if (w_start) begin
      w_run_next    = 1'b1;
      w_us_cnt_next = '0;
    end else if (r_run && w_tick) begin
      w_us_cnt_next = (r_us_cnt == LAST_US) ? '0 : r_us_cnt + 1'b1;
      if (w_frame && !bus.en) w_run_next = 1'b0;
    end

    if (w_load) begin
      w_sat_next     = (bus.pul_len < P_MIN) || (bus.pul_len > P_MAX);
      w_applied_next = slew_step(r_pul_applied, w_target, P_SLEW);
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_run         <= 1'b0;
      r_us_cnt      <= '0;
      r_ctl         <= 1'b0;
      r_frame_start <= 1'b0;
      r_pul_applied <= P_RST;
      r_sat         <= 1'b0;
    end else begin
      r_run         <= w_run_next;
      r_us_cnt      <= w_us_cnt_next;
      r_ctl         <= w_run_next && (w_us_cnt_next < w_applied_next);
      r_frame_start <= w_load;
      r_pul_applied <= w_applied_next;
      r_sat         <= w_sat_next;
    end
  end

  assign bus.CTL         = r_ctl;
  assign bus.frame_start = r_frame_start;
  assign bus.pul_applied = r_pul_applied;
  assign bus.sat         = r_sat;

endmodule

// File: tb/tb_servo_pwm_slew.sv
module tb_servo_pwm_slew;

  localparam int CD   = 2;
  localparam int FU   = 300;
  localparam int PMIN = 50;
  localparam int PMAX = 250;
  localparam int PRST = 150;
  localparam int SL   = 20;
  localparam int FC   = CD * FU;   // cycles per frame

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  servo_pwm_slew_if bus ();
  servo_pwm_slew_if sbus ();

  assign sbus.en      = bus.en;
  assign sbus.pul_len = bus.pul_len;

  servo_pwm_slew #(.CLK_DIV(CD), .FRAME_US(FU), .PUL_MIN(PMIN), .PUL_MAX(PMAX),
                   .PUL_RESET(PRST), .SLEW_US(SL)) dut (
    .CLK (clk), .rst (rst), .bus (bus));

  servo_pwm_slew #(.CLK_DIV(CD), .FRAME_US(FU), .PUL_MIN(PMIN), .PUL_MAX(PMAX),
                   .PUL_RESET(PRST), .SLEW_US(0)) dut_snap (
    .CLK (clk), .rst (rst), .bus (sbus));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Called on the sampling edge of a frame_start cycle. Counts CTL-high
  // cycles and cycles until the next frame_start (bounded at 2 frames).
  // At cycle mid_cyc either drops en or changes the command.
  int run_last, run_after;
  task automatic measure(input int mid_cyc, input int mid_val, input bit stop,
                         output int hi, output int per);
    hi = 0; per = 0;
    do begin
      if (per == mid_cyc) begin
        if (stop) bus.en = 1'b0;
        else      bus.pul_len = 16'(mid_val);
      end
      if (per == FC - 1) run_last  = int'(dut.r_run);
      if (per == FC)     run_after = int'(dut.r_run);
      hi += int'(bus.CTL);
      per++;
      @(negedge clk);
    end while (!bus.frame_start && per < 2 * FC);
  endtask

  // Applied width, sat, snap-instance width, command issued mid-frame.
  int exp_app [13] = '{150,150,170,180,200,220,240,250,250,230,240,220,200};
  int exp_sat [13] = '{  0,  0,  0,  0,  1,  1,  1,  1,  0,  1,  0,  1,  0};
  int exp_snap[13] = '{150,150,180,180,250,250,250,250,250, 50,240, 50,150};
  int cmd     [13] = '{150,180,180,300,300,300,300,250, 10,240, 40,150,150};

  initial begin
    int hi, per;
    rst = 1'b1; bus.en = 1'b0; bus.pul_len = 16'd150;
    repeat (3) @(negedge clk);
    check("rst_ctl", int'(bus.CTL), 0);
    check("rst_fs", int'(bus.frame_start), 0);
    check("rst_app", int'(bus.pul_applied), PRST);
    check("rst_sat", int'(bus.sat), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_fs", int'(bus.frame_start), 0);
    check("idle_ctl", int'(bus.CTL), 0);

    bus.en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      check($sformatf("f%0d_fs", i), int'(bus.frame_start), 1);
      check($sformatf("f%0d_ctl_rise", i), int'(bus.CTL), 1);
      check($sformatf("f%0d_app", i), int'(bus.pul_applied), exp_app[i]);
      check($sformatf("f%0d_sat", i), int'(bus.sat), exp_sat[i]);
      check($sformatf("f%0d_snap_app", i), int'(sbus.pul_applied), exp_snap[i]);
      check($sformatf("f%0d_snap_sat", i), int'(sbus.sat), exp_sat[i]);
      if (i < 12) begin
        measure(160, cmd[i], 1'b0, hi, per);
        check($sformatf("f%0d_hi", i), hi, exp_app[i] * CD);
        check($sformatf("f%0d_period", i), per, FC);
      end else begin
        // en drops mid-pulse: pulse and frame must complete, then idle
        measure(140, 0, 1'b1, hi, per);
        check("stop_hi", hi, exp_app[i] * CD);
        check("stop_no_fs", per, 2 * FC);
        check("stop_run_last", run_last, 1);
        check("stop_run_after", run_after, 0);
        check("stop_ctl", int'(bus.CTL), 0);
      end
    end

    // Restart slews from the retained 200 toward 150
    bus.pul_len = 16'd150; bus.en = 1'b1;
    @(negedge clk);
    check("rs_fs", int'(bus.frame_start), 1);
    check("rs_ctl", int'(bus.CTL), 1);
    check("rs_app", int'(bus.pul_applied), 180);
    check("rs_snap_app", int'(sbus.pul_applied), 150);
    measure(160, 300, 1'b0, hi, per);
    check("rs_hi", hi, 360);
    check("rs_period", per, FC);
    check("rs2_app", int'(bus.pul_applied), 200);
    check("rs2_sat", int'(bus.sat), 1);
    check("rs2_snap_app", int'(sbus.pul_applied), 250);

    // Reset in the middle of a pulse
    repeat (100) @(negedge clk);
    check("pre_rst_ctl", int'(bus.CTL), 1);
    rst = 1'b1; bus.en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_ctl", int'(bus.CTL), 0);
    check("mrst_app", int'(bus.pul_applied), PRST);
    check("mrst_sat", int'(bus.sat), 0);
    check("mrst_fs", int'(bus.frame_start), 0);
    check("mrst_run", int'(dut.r_run), 0);
    repeat (4) @(negedge clk);
    check("mrst_idle_ctl", int'(bus.CTL), 0);

    // One saturated frame, then idle, then reset while idle
    bus.pul_len = 16'd300; bus.en = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    check("sf_fs", int'(bus.frame_start), 1);
    check("sf_app", int'(bus.pul_applied), 170);
    check("sf_sat", int'(bus.sat), 1);
    repeat (FC + 100) @(negedge clk);
    check("sf_idle_ctl", int'(bus.CTL), 0);
    check("sf_idle_app", int'(bus.pul_applied), 170);
    check("sf_idle_sat", int'(bus.sat), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("irst_app", int'(bus.pul_applied), PRST);
    check("irst_sat", int'(bus.sat), 0);
    check("irst_ctl", int'(bus.CTL), 0);
    check("irst_fs", int'(bus.frame_start), 0);
    check("irst_snap_app", int'(sbus.pul_applied), PRST);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
